// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file and its scoreboard.
package regfile_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef logic [4:0]              reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, flush wipes all.
// The population count is registered alongside the busy vector.
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_WR-1:0]    i_wr_en,
    input  logic [NUM_WR*AW-1:0] i_wr_addr,
    input  logic                 i_iss_en,
    input  logic [AW-1:0]        i_iss_addr,
    input  logic                 i_flush,
    output logic [NREGS-1:0]     o_busy,
    output logic [AW:0]          o_busy_cnt
);
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Flush beats issue; issue beats a same-cycle writeback because it is younger.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == AW'(r)))
                        w_busy_nxt[r] = 1'b0;
                end
                if (i_iss_en && (i_iss_addr == AW'(r)))
                    w_busy_nxt[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++)
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with optional write-to-read bypass,
// hardwired zero register and a busy scoreboard for decode hazard checks.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);
    logic [XLEN-1:0]   r_mem [NREGS];
    logic [NUM_WR-1:0] w_wr_ok;
    logic [NREGS-1:0]  w_busy;

    // A write to x0 is dropped entirely when it is hardwired, including the bypass.
    always_comb begin
        w_wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++)
            w_wr_ok[j] = wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end

    // Ports are visited in index order so the highest-index writer lands last.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int r = 0; r < NREGS; r++)
                r_mem[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j])
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_ok[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]))
                        rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0))
                rd_data[k*XLEN +: XLEN] = '0;
            rd_busy[k] = w_busy[rd_addr[k*AW +: AW]];
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_flush    (flush),
        .o_busy     (w_busy),
        .o_busy_cnt (busy_cnt)
    );
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-ported integer register file. Next generation of the single-issue 2R1W file.
- Adds configurable width, depth, read and write port counts, and write-to-read bypass.
- Adds a per-register busy scoreboard: issue sets a register's busy bit, writeback clears it.
- Sits between decode/issue and writeback in the pipelined core. Decode reads operands and hazard status in the same cycle.

Parameters:
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers; power of two, >= 2.
- NUM_RD, 2: number of read ports.
- NUM_WR, 1: number of write ports; 1..4.
- BYPASS, 1: 1 = a same-cycle write is visible on read ports; 0 = reads return stored value only.
- ZERO_REG, 1: 1 = register 0 hardwired to zero and never busy.
- AW, $clog2(NREGS): address width (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NUM_RD  busy bit of the register addressed by each read port.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline squash).
- busy_cnt  out  AW+1  number of currently busy registers.

Behaviour:
- Reset (i_rst low, async): all registers = 0, all busy bits = 0, busy_cnt = 0. With inputs idle: rd_data = 0, rd_busy = 0. Reset asserted mid-operation discards pending writes and issues immediately.
- Reads are combinational, 0-cycle latency.
  - BYPASS=1: if any enabled write port matches rd_addr[k] this cycle, rd_data[k] = that port's wr_data (highest-index matching port wins). Otherwise the stored value.
  - BYPASS=0: rd_data[k] = stored value only.
- Writes commit on the rising edge while wr_en[j] is high.
  - Several ports writing the same address in one cycle: the highest-index port wins. The same rule applies to the bypass path.
- ZERO_REG=1:
  - Writes to address 0 are ignored and are not bypassed; address 0 always reads 0.
  - iss_en with iss_addr=0 is ignored; busy[0] is always 0.
- Scoreboard, evaluated per register each edge, priority high to low:
  1. flush: all busy bits = 0. A same-cycle iss_en is dropped.
  2. iss_en with iss_addr == r: busy[r] = 1. Set beats a same-cycle writeback clear, since the new issue is younger.
  3. Any wr_en[j] with wr_addr[j] == r: busy[r] = 0.
- rd_busy[k] = busy[rd_addr[k]] as registered. No bypass of same-cycle issue or clear. A clearing write therefore shows the busy bit still high in that cycle while the data is already bypassed; decode uses rd_data when BYPASS=1.
- busy_cnt: registered population count of the busy bits, updated on the same edge as the busy bits. Its range 0..NREGS needs AW+1 bits.
- Issue to an already busy register keeps it busy (WAW); busy_cnt is unchanged.
- Write to a non-busy register is legal; the data updates and the busy bit stays 0.

Decomposition:
- Shared package regfile_pkg:
  - XLEN_DEFAULT = 32, NREGS_DEFAULT = 32.
  - typedef reg_addr_t = logic [4:0].
  - typedef xlen_t = logic [XLEN_DEFAULT-1:0].
- One sub-module, regfile_scoreboard:
  - Owns the busy vector, the set/clear/flush priority and busy_cnt.
  - Parametrised by NREGS, NUM_WR, ZERO_REG.
- The data array, write arbitration and bypass muxes stay in regfile_mp.

Test Plan:
1. Reset, then read all 32 addresses on 2 ports -> rd_data = 0 and rd_busy = 0 everywhere; busy_cnt = 0.
2. Write x5 = 0xDEADBEEF with rd_addr[0]=5 in the same cycle -> rd_data[0] = 0xDEADBEEF that cycle (BYPASS=1) and after the edge. With BYPASS=0 -> 0 that cycle, 0xDEADBEEF next cycle.
3. Write x0 = 0xFFFFFFFF and iss_en to x0 -> rd_data for x0 = 0, busy[0] = 0, busy_cnt = 0.
4. NUM_WR=2: port0 writes x7 = 0x11 and port1 writes x7 = 0x22 in the same cycle -> x7 = 0x22 (both bypass and stored).
5. Issue x3 -> next cycle rd_busy = 1 and busy_cnt = 1. Then iss_en x3 plus writeback x3 in one cycle -> still busy, busy_cnt = 1. Writeback x3 alone -> busy = 0, busy_cnt = 0.
6. Issue x1, x2, x4 -> busy_cnt = 3. Assert flush with iss_en x9 -> next cycle busy_cnt = 0 and x9 not busy. Then pulse i_rst mid-write to x8 -> x8 = 0 and busy_cnt = 0.
